dcache_qspi_fill: RTL and testbench

- Memory-side counterpart of the data cache's nibble line port.
- Services the cache's pull (line fill) and push (line write-back) requests against an external QSPI PSRAM in quad mode.
- Drives the cache's rstrobe_d, wstrobe_d and dread, and consumes its dwrite nibbles.
- A local line buffer decouples the QSPI clock (clk/2) from the cache's 8-cycle contiguous strobe bursts.

---
 rtl/dcache_qspi_fill_if.sv | 27 ++
 rtl/dcache_qspi_fill.sv | 226 ++++++++++++++++++++++
 tb/tb_dcache_qspi_fill.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_qspi_fill_if.sv
// Cache-side line port of dcache_qspi_fill.
// The cache (master) raises pull/push with the line tag and supplies dwrite
// nibbles while rstrobe_d is high. The fill engine (slave) returns dread
// nibbles while wstrobe_d is high and reports busy/done.
interface dcache_qspi_fill_if #(
    parameter int PA = 22
);
    logic            pull;
    logic            push;
    logic [PA-3:0]   tag;
    logic [3:0]      dwrite;
    logic [3:0]      dread;
    logic            rstrobe_d;
    logic            wstrobe_d;
    logic            busy;
    logic            done;

    modport master (
        output pull, push, tag, dwrite,
        input  dread, rstrobe_d, wstrobe_d, busy, done
    );

    modport slave (
        input  pull, push, tag, dwrite,
        output dread, rstrobe_d, wstrobe_d, busy, done
    );
endinterface

// File: rtl/dcache_qspi_fill.sv
// dcache_qspi_fill: memory-side engine for the data cache nibble line port.
// Line fills (pull) read a 4-byte line from a quad-mode PSRAM and stream it
// into the cache as an 8-cycle wstrobe_d burst; write-backs (push) first
// collect an 8-cycle rstrobe_d burst from the cache, then write it out.
// One SCK period is two clk cycles: phase 0 (sck=0, dout changes) and
// phase 1 (sck=1); qspi_din is captured on the clk edge that ends phase 1.
// Optional feature macro: QSPI_CS_GAP_EN stretches the closing cs_n-high
// gap to CS_GAP clks, with done in the last of them.
module dcache_qspi_fill #(
    parameter int         LINE_LENGTH = 4,
    parameter int         PA          = 22,
    parameter logic [7:0] CMD_READ    = 8'hEB,
    parameter logic [7:0] CMD_WRITE   = 8'h38,
    parameter int         DUMMY       = 6,
    parameter int         CS_GAP      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    dcache_qspi_fill_if.slave   cif,
    output logic                qspi_cs_n,
    output logic                qspi_sck,
    output logic [3:0]          qspi_dout,
    output logic                qspi_oe,
    input  logic [3:0]          qspi_din
);

    localparam int NIBBLES   = 2 * LINE_LENGTH;
    localparam int CMD_CLKS  = 4;
    localparam int ADDR_CLKS = 12;
    localparam int WAIT_CLKS = 2 * DUMMY;
    localparam int DATA_CLKS = 2 * NIBBLES;
`ifdef QSPI_CS_GAP_EN
    localparam int GAP_CLKS  = CS_GAP;
`else
    // CS_GAP has no effect in this build; the closing gap is one clk.
    localparam int GAP_CLKS  = 1 + 0 * CS_GAP;
`endif
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             is_push;
    logic [PA-3:0]    tag_q;
    logic [3:0]       line_buf [NIBBLES];
    logic [23:0]      addr24;
    logic [7:0]       opcode;
    logic [3:0]       addr_nib;

    logic             cs_n_c;
    logic             sck_c;
    logic             oe_c;
    logic [3:0]       dout_c;
    logic             rstrobe_c;
    logic             wstrobe_c;
    logic [3:0]       dread_c;
    logic             busy_c;
    logic             done_c;

    assign addr24 = {{(24 - PA){1'b0}}, tag_q, 2'b00};
    assign opcode = is_push ? CMD_WRITE : CMD_READ;

    // Address nibble for the current ADDR SCK cycle, most significant first.
    always_comb begin
        addr_nib = 4'h0;
        case (cnt[3:1])
            3'd0:    addr_nib = addr24[23:20];
            3'd1:    addr_nib = addr24[19:16];
            3'd2:    addr_nib = addr24[15:12];
            3'd3:    addr_nib = addr24[11:8];
            3'd4:    addr_nib = addr24[7:4];
            3'd5:    addr_nib = addr24[3:0];
            default: addr_nib = 4'h0;
        endcase
    end

    // State register and per-phase clk counter; the counter restarts at
    // every phase transition so it never spills into the next phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;
        end
    end

    // Request latch: direction and line tag are captured only when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_push <= 1'b0;
            tag_q   <= '0;
        end else if (state == S_IDLE && (cif.push || cif.pull)) begin
            is_push <= cif.push;
            tag_q   <= cif.tag;
        end
    end

    // Line buffer: filled from the cache in LOAD, from the PSRAM in read DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NIBBLES; i++) begin
                line_buf[i] <= 4'h0;
            end
        end else if (state == S_LOAD) begin
            line_buf[cnt[2:0]] <= cif.dwrite;
        end else if (state == S_DATA && !is_push && cnt[0]) begin
            line_buf[cnt[3:1]] <= qspi_din;
        end
    end

    // Next-state and output decode from state and phase counter.
    always_comb begin
        state_nx  = state;
        cnt_clr   = 1'b0;
        cs_n_c    = 1'b1;
        sck_c     = 1'b0;
        oe_c      = 1'b0;
        dout_c    = 4'h0;
        rstrobe_c = 1'b0;
        wstrobe_c = 1'b0;
        dread_c   = 4'h0;
        done_c    = 1'b0;
        busy_c    = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (cif.push) begin
                    state_nx = S_LOAD;
                end else if (cif.pull) begin
                    state_nx = S_CMD;
                end
            end
            S_LOAD: begin
                rstrobe_c = 1'b1;
                if (cnt == CNT_W'(NIBBLES - 1)) begin
                    state_nx = S_CMD;
                    cnt_clr  = 1'b1;
                end
            end
            S_CMD: begin
                cs_n_c = 1'b0;
                sck_c  = cnt[0];
                oe_c   = 1'b1;
                dout_c = cnt[1] ? opcode[3:0] : opcode[7:4];
                if (cnt == CNT_W'(CMD_CLKS - 1)) begin
                    state_nx = S_ADDR;
                    cnt_clr  = 1'b1;
                end
            end
            S_ADDR: begin
                cs_n_c = 1'b0;
                sck_c  = cnt[0];
                oe_c   = 1'b1;
                dout_c = addr_nib;
                if (cnt == CNT_W'(ADDR_CLKS - 1)) begin
                    state_nx = is_push ? S_DATA : S_WAIT;
                    cnt_clr  = 1'b1;
                end
            end
            S_WAIT: begin
                cs_n_c = 1'b0;
                sck_c  = cnt[0];
                if (cnt == CNT_W'(WAIT_CLKS - 1)) begin
                    state_nx = S_DATA;
                    cnt_clr  = 1'b1;
                end
            end
            S_DATA: begin
                cs_n_c = 1'b0;
                sck_c  = cnt[0];
                oe_c   = is_push;
                dout_c = is_push ? line_buf[cnt[3:1]] : 4'h0;
                if (cnt == CNT_W'(DATA_CLKS - 1)) begin
                    state_nx = is_push ? S_GAP : S_DRAIN;
                    cnt_clr  = 1'b1;
                end
            end
            S_DRAIN: begin
                cs_n_c    = 1'b0;
                wstrobe_c = 1'b1;
                dread_c   = line_buf[cnt[2:0]];
                if (cnt == CNT_W'(NIBBLES - 1)) begin
                    state_nx = S_GAP;
                    cnt_clr  = 1'b1;
                end
            end
            S_GAP: begin
                done_c = (cnt == CNT_W'(GAP_CLKS - 1));
                busy_c = !done_c;
                if (done_c) begin
                    state_nx = S_IDLE;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_clr  = 1'b1;
            end
        endcase
    end

    assign qspi_cs_n     = cs_n_c;
    assign qspi_sck      = sck_c;
    assign qspi_oe       = oe_c;
    assign qspi_dout     = dout_c;
    assign cif.rstrobe_d = rstrobe_c;
    assign cif.wstrobe_d = wstrobe_c;
    assign cif.dread     = dread_c;
    assign cif.busy      = busy_c;
    assign cif.done      = done_c;

endmodule

// File: tb/tb_dcache_qspi_fill.sv
// Testbench for dcache_qspi_fill: directed pull/push transactions against a
// small PSRAM model, with a scoreboard of expected QSPI and dread nibbles.
module tb_dcache_qspi_fill;

    localparam int PA = 22;
`ifdef QSPI_CS_GAP_EN
    localparam int GAP_CLKS = 4;
`else
    localparam int GAP_CLKS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       qspi_cs_n;
    logic       qspi_sck;
    logic       qspi_oe;
    logic [3:0] qspi_dout;
    logic [3:0] qspi_din = 4'h0;

    dcache_qspi_fill_if #(.PA(PA)) cif ();

    dcache_qspi_fill #(.PA(PA)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cif       (cif),
        .qspi_cs_n (qspi_cs_n),
        .qspi_sck  (qspi_sck),
        .qspi_dout (qspi_dout),
        .qspi_oe   (qspi_oe),
        .qspi_din  (qspi_din)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_dout  [$];
    logic [3:0]  exp_dread [$];
    logic [31:0] psram_data = 32'h0;
    int          sck_idx = 0;
    int          ws_total = 0;
    int          sck_viol = 0;
    int          hi_run = 0;
    int          min_gap = 1000;
    bit          seen_low = 1'b0;

    task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    // PSRAM model, bus-idle checks and scoreboard comparison of outputs.
    always @(negedge clk) begin
        if (qspi_cs_n) begin
            sck_idx = 0;
            hi_run++;
            if (qspi_sck) sck_viol++;
        end else begin
            if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            seen_low = 1'b1;
            hi_run   = 0;
            if (qspi_sck) begin
                if (sck_idx >= 14 && sck_idx < 22)
                    qspi_din = psram_data[31 - 4 * (sck_idx - 14) -: 4];
                sck_idx++;
            end
        end
        if (reset_n) begin
            if (!qspi_cs_n && qspi_oe && !qspi_sck) begin
                if (exp_dout.size() > 0) check("dout", 32'(qspi_dout), 32'(exp_dout.pop_front()));
                else check("dout_extra", 32'(exp_dout.size()), 32'd1);
            end
            if (cif.wstrobe_d) begin
                ws_total++;
                if (exp_dread.size() > 0) check("dread", 32'(cif.dread), 32'(exp_dread.pop_front()));
                else check("dread_extra", 32'(exp_dread.size()), 32'd1);
            end
        end
    end

    task automatic do_txn(input string nm, input bit dpush, input bit dpull, input bit exp_push,
                          input logic [19:0] t, input logic [31:0] wd, input logic [31:0] rd,
                          input bit keep_pull, input int exp_wait);
        logic [23:0] a;
        logic [7:0]  op;
        int n, w, k, rs_first, rs_last, rs_cnt, ws_first, ws_last, ws_cnt;
        int cs_first, cs_last, done_cyc, oe_dummy, oe_data;
        logic busy1, busy_done;
        a  = {2'b00, t, 2'b00};
        op = exp_push ? 8'h38 : 8'hEB;
        exp_dout.push_back(op[7:4]);
        exp_dout.push_back(op[3:0]);
        for (int i = 0; i < 6; i++) exp_dout.push_back(a[23 - 4 * i -: 4]);
        if (exp_push) begin
            for (int i = 0; i < 8; i++) exp_dout.push_back(wd[31 - 4 * i -: 4]);
        end else begin
            for (int i = 0; i < 8; i++) exp_dread.push_back(rd[31 - 4 * i -: 4]);
            psram_data = rd;
        end
        cif.push = dpush;
        cif.pull = dpull;
        cif.tag  = t;
        w = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end while (!cif.busy && w < 10);
        check({nm, "_start"}, 32'(w), 32'(exp_wait));
        n = 1; k = 0; done_cyc = 0; busy1 = 1'b0; busy_done = 1'b1;
        rs_first = 0; rs_last = 0; rs_cnt = 0; ws_first = 0; ws_last = 0; ws_cnt = 0;
        cs_first = 0; cs_last = 0; oe_dummy = 0; oe_data = 0;
        while (done_cyc == 0 && n <= 120) begin
            if (n == 1) busy1 = cif.busy;
            if (n == 2) cif.tag = ~t;
            if (cif.rstrobe_d) begin
                if (rs_cnt == 0) rs_first = n;
                rs_last = n;
                rs_cnt++;
                cif.dwrite = (k < 8) ? wd[31 - 4 * k -: 4] : 4'h0;
                k++;
            end
            if (cif.wstrobe_d) begin
                if (ws_cnt == 0) ws_first = n;
                ws_last = n;
                ws_cnt++;
            end
            if (!qspi_cs_n) begin
                if (cs_first == 0) cs_first = n;
                cs_last = n;
            end
            if (n >= 17 && n <= 28 && !qspi_cs_n && !qspi_oe) oe_dummy++;
            if (n >= 25 && n <= 40 && !qspi_cs_n && qspi_oe) oe_data++;
            if (cif.done) begin
                done_cyc  = n;
                busy_done = cif.busy;
                cif.push  = 1'b0;
                cif.pull  = keep_pull;
            end else begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_push ? 40 + GAP_CLKS : 52 + GAP_CLKS));
        check({nm, "_busy_c1"}, 32'(busy1), 32'd1);
        check({nm, "_busy_at_done"}, 32'(busy_done), 32'd0);
        check({nm, "_cs_first"}, 32'(cs_first), 32'(exp_push ? 9 : 1));
        check({nm, "_cs_last"}, 32'(cs_last), 32'(exp_push ? 40 : 52));
        if (exp_push) begin
            check({nm, "_rstrobe_first"}, 32'(rs_first), 32'd1);
            check({nm, "_rstrobe_last"}, 32'(rs_last), 32'd8);
            check({nm, "_rstrobe_cnt"}, 32'(rs_cnt), 32'd8);
            check({nm, "_wstrobe_cnt"}, 32'(ws_cnt), 32'd0);
            check({nm, "_oe_data"}, 32'(oe_data), 32'd16);
        end else begin
            check({nm, "_rstrobe_cnt"}, 32'(rs_cnt), 32'd0);
            check({nm, "_wstrobe_first"}, 32'(ws_first), 32'd45);
            check({nm, "_wstrobe_last"}, 32'(ws_last), 32'd52);
            check({nm, "_wstrobe_cnt"}, 32'(ws_cnt), 32'd8);
            check({nm, "_oe_dummy"}, 32'(oe_dummy), 32'd12);
        end
        check({nm, "_queue_empty"}, 32'(exp_dout.size() + exp_dread.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ws_before;
        logic [19:0] t3;
        reset_n    = 1'b0;
        cif.pull   = 1'b0;
        cif.push   = 1'b0;
        cif.tag    = '0;
        cif.dwrite = 4'h0;
        #1;
        check("rst_cs_n", 32'(qspi_cs_n), 32'd1);
        check("rst_sck", 32'(qspi_sck), 32'd0);
        check("rst_oe", 32'(qspi_oe), 32'd0);
        check("rst_dout", 32'(qspi_dout), 32'd0);
        check("rst_strobes", 32'({cif.rstrobe_d, cif.wstrobe_d}), 32'd0);
        check("rst_busy", 32'(cif.busy), 32'd0);
        check("rst_done", 32'(cif.done), 32'd0);
        check("rst_dread", 32'(cif.dread), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_txn("pull1", 1'b0, 1'b1, 1'b0, 20'h12345, 32'h0, 32'h12345678, 1'b0, 1);
        repeat (3) @(negedge clk);
        do_txn("push1", 1'b1, 1'b0, 1'b1, 20'h00001, 32'hABCDEF01, 32'h0, 1'b0, 1);
        repeat (3) @(negedge clk);
        do_txn("both_push", 1'b1, 1'b1, 1'b1, 20'h2A5C3, $urandom(), 32'h0, 1'b1, 1);
        do_txn("both_pull", 1'b0, 1'b1, 1'b0, 20'h2A5C3, 32'h0, $urandom(), 1'b0, 2);
        repeat (3) @(negedge clk);
        do_txn("b2b_a", 1'b0, 1'b1, 1'b0, 20'h0FFFF, 32'h0, $urandom(), 1'b1, 1);
        do_txn("b2b_b", 1'b0, 1'b1, 1'b0, 20'hFFFFF, 32'h0, $urandom(), 1'b0, 2);
        repeat (3) @(negedge clk);

        // Abort a pull in its DATA phase with reset.
        t3 = 20'h54321;
        exp_dout.push_back(4'hE);
        exp_dout.push_back(4'hB);
        for (int i = 0; i < 6; i++) begin
            logic [23:0] a3;
            a3 = {2'b00, t3, 2'b00};
            exp_dout.push_back(a3[23 - 4 * i -: 4]);
        end
        psram_data = $urandom();
        cif.pull = 1'b1;
        cif.tag  = t3;
        repeat (35) @(posedge clk);
        #1;
        reset_n   = 1'b0;
        cif.pull  = 1'b0;
        ws_before = ws_total;
        #1;
        check("abort_cs_n", 32'(qspi_cs_n), 32'd1);
        check("abort_oe", 32'(qspi_oe), 32'd0);
        check("abort_busy", 32'(cif.busy), 32'd0);
        check("abort_sck", 32'(qspi_sck), 32'd0);
        check("abort_cmd_addr_seen", 32'(exp_dout.size()), 32'd0);
        exp_dread.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_wstrobe", 32'(ws_total - ws_before), 32'd0);
        check("abort_dread", 32'(cif.dread), 32'd0);
        do_txn("pull_after_abort", 1'b0, 1'b1, 1'b0, 20'h3C3C3, 32'h0, $urandom(), 1'b0, 1);
        repeat (4) @(negedge clk);

        check("sck_idle_low", 32'(sck_viol), 32'd0);
        check("cs_gap_min", 32'(min_gap >= GAP_CLKS), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
